// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller and the core's ALU operand muxes:
// forwarding selects and hazard FSM states.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_EXM  = 2'b10,
        FWD_MWB  = 2'b01
    } fwdSel_t;

    typedef enum logic {
        HZ_RUN = 1'b0,
        HZ_MC  = 1'b1
    } hzState_t;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand: EX/MEM has priority over MEM/WB,
// and register 0 is never forwarded.
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] srcReg,
    input  logic [REG_ADDR_W-1:0] mDst,
    input  logic                  mRegW,
    input  logic [REG_ADDR_W-1:0] wbDst,
    input  logic                  wbRegW,
    output logic [1:0]            sel
);

    always_comb begin
        if (mRegW && (mDst != '0) && (mDst == srcReg)) begin
            sel = FWD_EXM;
        end else if (wbRegW && (wbDst != '0) && (wbDst == srcReg)) begin
            sel = FWD_MWB;
        end else begin
            sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, counted multi-cycle EX stall, load-use
// bubble and operand forwarding. Define HAZARD_PERF_CNT_EN to build the perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int N_STAGES   = 4,
    parameter int REG_ADDR_W = 5,
    parameter int BR_STAGE   = 2,
    parameter int MC_W       = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_regw,
    input  logic                  ex_memr,
    input  logic [REG_ADDR_W-1:0] m_dst,
    input  logic                  m_regw,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    input  logic                  wb_regw,
    input  logic                  branch_taken,
    input  logic                  mc_start,
    input  logic [MC_W-1:0]       mc_cycles,
    output logic                  pc_write,
    output logic [N_STAGES-1:0]   pipe_lock,
    output logic [N_STAGES-1:0]   pipe_clear,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_events
);

    hzState_t        state;
    logic [MC_W-1:0] mcCnt;
    logic            mcLaunch;
    logic            mcActive;
    logic            loadUse;

    assign mcLaunch = (state == HZ_RUN) && mc_start && (mc_cycles != '0);
    assign mcActive = (state == HZ_MC) || mcLaunch;
    assign loadUse  = (state == HZ_RUN) && ex_memr && ex_regw && (ex_dst != '0) &&
                      ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_write   = 1'b1;
        pipe_lock  = '1;
        pipe_clear = '0;
        if (branch_taken) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (i <= BR_STAGE) pipe_clear[i] = 1'b1;
            end
        end else if (mcActive) begin
            pc_write      = 1'b0;
            pipe_lock[0]  = 1'b0;
            pipe_lock[1]  = 1'b0;
            pipe_clear[2] = 1'b1;
        end else if (loadUse) begin
            pc_write      = 1'b0;
            pipe_lock[0]  = 1'b0;
            pipe_clear[1] = 1'b1;
        end
    end

    // A taken branch aborts any pending multi-cycle op.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= HZ_RUN;
            mcCnt <= '0;
        end else if (branch_taken) begin
            state <= HZ_RUN;
            mcCnt <= '0;
        end else if (state == HZ_RUN) begin
            if (mcLaunch) begin
                mcCnt <= mc_cycles - MC_W'(1);
                state <= (mc_cycles == MC_W'(1)) ? HZ_RUN : HZ_MC;
            end
        end else begin
            mcCnt <= mcCnt - MC_W'(1);
            if (mcCnt == MC_W'(1)) state <= HZ_RUN;
        end
    end

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwdA (
        .srcReg (ex_rs),
        .mDst   (m_dst),
        .mRegW  (m_regw),
        .wbDst  (wb_dst),
        .wbRegW (wb_regw),
        .sel    (forward_a)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwdB (
        .srcReg (ex_rt),
        .mDst   (m_dst),
        .mRegW  (m_regw),
        .wbDst  (wb_dst),
        .wbRegW (wb_regw),
        .sel    (forward_b)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stallCnt;
    logic [PERF_CNT_W-1:0] flushCnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!pc_write && (stallCnt != '1)) stallCnt <= stallCnt + PERF_CNT_W'(1);
            if (branch_taken && (flushCnt != '1)) flushCnt <= flushCnt + PERF_CNT_W'(1);
        end
    end

    assign stall_cycles = stallCnt;
    assign flush_events = flushCnt;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int N_STAGES   = 4;
    localparam int REG_ADDR_W = 5;
    localparam int BR_STAGE   = 2;
    localparam int MC_W       = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [8:0] CTL_NORMAL = {1'b1, 4'b1111, 4'b0000};
    localparam logic [8:0] CTL_MC     = {1'b0, 4'b1100, 4'b0100};
    localparam logic [8:0] CTL_LU     = {1'b0, 4'b1110, 4'b0010};
    localparam logic [8:0] CTL_BR     = {1'b1, 4'b1111, 4'b0111};

    logic                  clock = 1'b0;
    logic                  reset;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, m_dst, wb_dst;
    logic                  id_uses_rs, id_uses_rt, ex_regw, ex_memr, m_regw, wb_regw;
    logic                  branch_taken, mc_start;
    logic [MC_W-1:0]       mc_cycles;
    logic                  pc_write;
    logic [N_STAGES-1:0]   pipe_lock, pipe_clear;
    logic [1:0]            forward_a, forward_b;
    logic [31:0]           stall_cycles, flush_events;
    logic [8:0]            ctl;

    int passChecks = 0;
    int totalChecks = 0;

    assign ctl = {pc_write, pipe_lock, pipe_clear};

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(
        .N_STAGES(N_STAGES), .REG_ADDR_W(REG_ADDR_W), .BR_STAGE(BR_STAGE), .MC_W(MC_W)
    ) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_regw(ex_regw), .ex_memr(ex_memr),
        .m_dst(m_dst), .m_regw(m_regw), .wb_dst(wb_dst), .wb_regw(wb_regw),
        .branch_taken(branch_taken), .mc_start(mc_start), .mc_cycles(mc_cycles),
        .pc_write(pc_write), .pipe_lock(pipe_lock), .pipe_clear(pipe_clear),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic clearInputs();
        id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = '0; ex_rt = '0; ex_dst = '0; ex_regw = 0; ex_memr = 0;
        m_dst = '0; m_regw = 0; wb_dst = '0; wb_regw = 0;
        branch_taken = 0; mc_start = 0; mc_cycles = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        totalChecks++;
        if ({forward_a, forward_b} !== 4'b0000) $display("FAIL reset_fwd: got %b expected 0000", {forward_a, forward_b});
        else passChecks++;
        totalChecks++;
        if ({stall_cycles, flush_events} !== 64'd0) $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cycles, flush_events);
        else passChecks++;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_mc_stall();
        clearInputs();
        mc_start = 1; mc_cycles = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            totalChecks++;
            if (ctl !== CTL_MC) $display("FAIL mc3_stall[%0d]: got %b expected %b", k, ctl, CTL_MC);
            else passChecks++;
            @(posedge clock); #1;
            mc_start = (k < 1);   // a new request while stalling must be ignored
            mc_cycles = 4'd7;
        end
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL mc3_done: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        totalChecks++;
        if (stall_cycles !== (PERF ? 32'd3 : 32'd0)) $display("FAIL mc3_stall_cnt: got %0d expected %0d", stall_cycles, PERF ? 3 : 0);
        else passChecks++;
        @(posedge clock); #1;
        mc_start = 1; mc_cycles = 4'd0;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL mc0_nostall: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        @(posedge clock); #1;
        mc_cycles = 4'd1;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_MC) $display("FAIL mc1_stall: got %b expected %b", ctl, CTL_MC);
        else passChecks++;
        @(posedge clock); #1;
        mc_start = 0;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL mc1_done: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        @(posedge clock); #1;
    endtask

    task automatic test_load_use();
        clearInputs();
        ex_memr = 1; ex_regw = 1; ex_dst = 5'd2; id_rs = 5'd2; id_uses_rs = 1; id_rt = 5'd7;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_LU) $display("FAIL lu_bubble: got %b expected %b", ctl, CTL_LU);
        else passChecks++;
        @(posedge clock); #1;
        ex_memr = 0; ex_regw = 0; ex_dst = '0; m_dst = 5'd2; m_regw = 1;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL lu_after: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        @(posedge clock); #1;
        ex_rs = 5'd2; m_dst = '0; m_regw = 0; wb_dst = 5'd2; wb_regw = 1; id_uses_rs = 0;
        @(negedge clock);
        totalChecks++;
        if ({ctl, forward_a} !== {CTL_NORMAL, 2'b01}) $display("FAIL lu_fwd_mwb: got %b/%b expected %b/01", ctl, forward_a, CTL_NORMAL);
        else passChecks++;
        // rt dependency stalls; rt not read or load to r0 does not
        ex_memr = 1; ex_regw = 1; ex_dst = 5'd5; id_rt = 5'd5; id_uses_rt = 1; id_rs = 5'd0;
        #1;
        totalChecks++;
        if (ctl !== CTL_LU) $display("FAIL lu_rt: got %b expected %b", ctl, CTL_LU);
        else passChecks++;
        id_uses_rt = 0;
        #1;
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL lu_rt_unused: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        id_uses_rt = 1; ex_dst = 5'd0; id_rt = 5'd0;
        #1;
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL lu_r0: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        @(posedge clock); #1;
    endtask

    task automatic test_forwarding();
        clearInputs();
        m_dst = 5'd3; wb_dst = 5'd3; ex_rs = 5'd3; m_regw = 1; wb_regw = 1;
        @(negedge clock);
        totalChecks++;
        if (forward_a !== 2'b10) $display("FAIL fwd_both: got %b expected 10", forward_a);
        else passChecks++;
        m_dst = '0;
        #1;
        totalChecks++;
        if (forward_a !== 2'b01) $display("FAIL fwd_mdst0: got %b expected 01", forward_a);
        else passChecks++;
        wb_dst = '0;
        #1;
        totalChecks++;
        if (forward_a !== 2'b00) $display("FAIL fwd_none: got %b expected 00", forward_a);
        else passChecks++;
        ex_rt = 5'd9; m_dst = 5'd9; wb_dst = 5'd9; m_regw = 0;
        #1;
        totalChecks++;
        if ({forward_a, forward_b} !== 4'b0001) $display("FAIL fwd_b_mwb: got %b expected 0001", {forward_a, forward_b});
        else passChecks++;
        m_regw = 1;
        #1;
        totalChecks++;
        if (forward_b !== 2'b10) $display("FAIL fwd_b_exm: got %b expected 10", forward_b);
        else passChecks++;
        @(posedge clock); #1;
    endtask

    task automatic test_branch_flush();
        clearInputs();
        mc_start = 1; mc_cycles = 4'd4;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_MC) $display("FAIL br_mc_first: got %b expected %b", ctl, CTL_MC);
        else passChecks++;
        @(posedge clock); #1;
        mc_start = 0; branch_taken = 1;
        ex_memr = 1; ex_regw = 1; ex_dst = 5'd4; id_rs = 5'd4; id_uses_rs = 1;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_BR) $display("FAIL br_in_mc: got %b expected %b", ctl, CTL_BR);
        else passChecks++;
        @(posedge clock); #1;
        clearInputs();
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL br_after_mc: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        @(posedge clock); #1;
        branch_taken = 1; mc_start = 1; mc_cycles = 4'd5;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_BR) $display("FAIL br_vs_mcstart: got %b expected %b", ctl, CTL_BR);
        else passChecks++;
        @(posedge clock); #1;
        clearInputs();
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL br_no_mc: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_stall();
        clearInputs();
        mc_start = 1; mc_cycles = 4'd5;
        @(negedge clock);
        @(posedge clock); #1;
        mc_start = 0;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_MC) $display("FAIL rst_pre_stall: got %b expected %b", ctl, CTL_MC);
        else passChecks++;
        #2 reset = 1'b1;
        #1;
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL rst_mid_stall: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        totalChecks++;
        if ({stall_cycles, flush_events} !== 64'd0) $display("FAIL rst_mid_cnt: got %0d/%0d expected 0/0", stall_cycles, flush_events);
        else passChecks++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        totalChecks++;
        if (ctl !== CTL_NORMAL) $display("FAIL rst_no_residual: got %b expected %b", ctl, CTL_NORMAL);
        else passChecks++;
        @(posedge clock); #1;
    endtask

    function automatic logic [1:0] fwdRef(input logic [REG_ADDR_W-1:0] src);
        if (m_regw && m_dst != 0 && m_dst == src) return 2'b10;
        if (wb_regw && wb_dst != 0 && wb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    // Model state: number of stall cycles still owed after the current one.
    task automatic test_random();
        int   owed = 0;
        int   expStall = 0;
        int   expFlush = 0;
        bit   stallNow, luNow;
        logic [8:0] expCtl;
        for (int n = 0; n < 400; n++) begin
            id_rs = 5'($urandom_range(0, 3));  id_rt = 5'($urandom_range(0, 3));
            ex_rs = 5'($urandom_range(0, 3));  ex_rt = 5'($urandom_range(0, 3));
            ex_dst = 5'($urandom_range(0, 3)); m_dst = 5'($urandom_range(0, 3));
            wb_dst = 5'($urandom_range(0, 3));
            {id_uses_rs, id_uses_rt, ex_regw, ex_memr, m_regw, wb_regw} = 6'($urandom);
            branch_taken = ($urandom_range(0, 9) == 0);
            mc_start = ($urandom_range(0, 5) == 0);
            mc_cycles = 4'($urandom_range(0, 5));

            stallNow = (owed > 0) || (mc_start && mc_cycles != 0);
            luNow = (owed == 0) && ex_memr && ex_regw && ex_dst != 0 &&
                    ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
            if (branch_taken)  expCtl = CTL_BR;
            else if (stallNow) expCtl = CTL_MC;
            else if (luNow)    expCtl = CTL_LU;
            else               expCtl = CTL_NORMAL;

            @(negedge clock);
            totalChecks++;
            if (ctl !== expCtl) $display("FAIL rnd_ctl[%0d]: got %b expected %b", n, ctl, expCtl);
            else passChecks++;
            totalChecks++;
            if ({forward_a, forward_b} !== {fwdRef(ex_rs), fwdRef(ex_rt)})
                $display("FAIL rnd_fwd[%0d]: got %b expected %b", n, {forward_a, forward_b}, {fwdRef(ex_rs), fwdRef(ex_rt)});
            else passChecks++;

            if (expCtl[8] == 1'b0) expStall++;
            if (branch_taken) expFlush++;
            if (branch_taken)   owed = 0;
            else if (owed > 0)  owed--;
            else if (stallNow)  owed = int'(mc_cycles) - 1;
            @(posedge clock); #1;
        end
        clearInputs();
        @(negedge clock);
        totalChecks++;
        if (stall_cycles !== (PERF ? 32'(expStall) : 32'd0))
            $display("FAIL rnd_stall_cnt: got %0d expected %0d", stall_cycles, PERF ? expStall : 0);
        else passChecks++;
        totalChecks++;
        if (flush_events !== (PERF ? 32'(expFlush) : 32'd0))
            $display("FAIL rnd_flush_cnt: got %0d expected %0d", flush_events, PERF ? expFlush : 0);
        else passChecks++;
    endtask

    initial begin
        test_reset();
        test_mc_stall();
        test_load_use();
        test_forwarding();
        test_branch_flush();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
